uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_arb_rr_pick.sv | 36 +++
 rtl/uart_tx_arb.sv | 158 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, arbiter FSM encoding, byte payload, clog2 helper.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ARB        = 3'd0,
    ISSUE      = 3'd1,
    LAUNCH     = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } arb_state_e;

  // One byte headed for the transmitter plus its end-of-burst marker
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } tx_beat_t;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [clog2(NUM_REQ)-1:0] ptr,
  output logic [clog2(NUM_REQ)-1:0] idx_c,
  output logic                      found_c
);

  localparam int unsigned ID_W = clog2(NUM_REQ);
  localparam int unsigned CW   = ID_W + 1;

  logic [CW-1:0]   cand;
  logic [ID_W-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the nearest valid requester wins
  always_comb begin
    idx_c    = '0;
    found_c  = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = CW'(ptr) + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      cand_idx = cand[ID_W-1:0];
      if (valid[cand_idx]) begin
        idx_c   = cand_idx;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one uart_tx from NUM_REQ byte sources, with burst locking
// and a forced release when a locked burst stalls for LOCK_TIMEOUT cycles.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_en,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        active,
  output logic                        lock_abort
);

  localparam int unsigned ID_W  = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  pick_idx_c, next_ptr_c;
  logic             pick_found_c;
  tx_beat_t         beat_q, beat_d, sel_beat_c;
  logic             sel_valid_c;
  logic             lock_q, lock_d;
  logic             abort_d;
  logic             accept_c;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             tx_en_q, active_q, lock_abort_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .valid   (req_valid),
    .ptr     (rr_ptr_q),
    .idx_c   (pick_idx_c),
    .found_c (pick_found_c)
  );

  // Route the granted requester's byte, last marker and valid
  always_comb begin
    sel_beat_c  = '0;
    sel_valid_c = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_q == ID_W'(r)) begin
        sel_beat_c.data = req_data[r*DATA_W +: DATA_W];
        sel_beat_c.last = req_last[r];
        sel_valid_c     = req_valid[r];
      end
    end
  end

  assign accept_c   = (state_q == ISSUE) && sel_valid_c && !tx_busy;
  assign next_ptr_c = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  // Ready is only ever offered to the granted requester, and only while the UART is free
  assign req_ready = ((state_q == ISSUE) && !tx_busy) ? (NUM_REQ'(1) << grant_q) : '0;

  // Next-state and register-input logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_d     = beat_q;
    lock_d     = lock_q;
    idle_cnt_d = idle_cnt_q;
    abort_d    = 1'b0;
    case (state_q)
      ARB: begin
        if (pick_found_c) begin
          grant_d    = pick_idx_c;
          lock_d     = 1'b0;
          idle_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (accept_c) begin
          beat_d     = sel_beat_c;
          idle_cnt_d = '0;
          state_d    = LAUNCH;
        end else if (!lock_q) begin
          if (!sel_valid_c) state_d = ARB;
        end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          abort_d    = 1'b1;
          rr_ptr_d   = next_ptr_c;
          lock_d     = 1'b0;
          idle_cnt_d = '0;
          state_d    = ARB;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      LAUNCH: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (beat_q.last) begin
            rr_ptr_d = next_ptr_c;
            lock_d   = 1'b0;
            state_d  = ARB;
          end else begin
            lock_d     = 1'b1;
            idle_cnt_d = '0;
            state_d    = ISSUE;
          end
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State and datapath registers; outputs are registered off the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      beat_q       <= '0;
      lock_q       <= 1'b0;
      idle_cnt_q   <= '0;
      tx_en_q      <= 1'b0;
      active_q     <= 1'b0;
      lock_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_q       <= beat_d;
      lock_q       <= lock_d;
      idle_cnt_q   <= idle_cnt_d;
      tx_en_q      <= (state_d == LAUNCH);
      active_q     <= (state_d != ARB);
      lock_abort_q <= abort_d;
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = beat_q.data;
  assign grant_id   = grant_q;
  assign active     = active_q;
  assign lock_abort = lock_abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a behavioural uart_tx busy model and queued requesters.
module tb_uart_tx_arb;

  localparam int unsigned NR       = 4;
  localparam int unsigned BUSY_LEN = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic [1:0]    grant_id;
  logic          active;
  logic          lock_abort;

  int vectors     = 0;
  int miscompares = 0;

  // Requester byte queues: {last, data}
  logic [8:0] src_mem [NR][16];
  int         src_wr  [NR] = '{0, 0, 0, 0};
  int         src_rd  [NR] = '{0, 0, 0, 0};

  // Transmit log
  logic [7:0] log_data [64];
  logic [1:0] log_gid  [64];
  int         log_n = 0;

  logic [NR-1:0] acc_pend   = '0;
  logic          tx_en_prev = 1'b0;
  int  busy_cnt    = 0;
  int  tot_acc     = 0;
  int  tot_en      = 0;
  bit  lat_err     = 1'b0;
  bit  long_en_err = 1'b0;
  bit  multi_err   = 1'b0;
  bit  stray_err   = 1'b0;

  uart_tx_arb #(
    .NUM_REQ      (NR),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .lock_abort (lock_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: busy rises the cycle after tx_en and stays up BUSY_LEN cycles
  always @(posedge clk) begin
    if (tx_en) begin
      busy_cnt <= BUSY_LEN;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  // Requester sources and monitors, evaluated mid-cycle
  always @(negedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (acc_pend[r]) begin
        src_rd[r] = src_rd[r] + 1;
        tot_acc   = tot_acc + 1;
      end
    end
    if (tx_en !== (|acc_pend)) lat_err = 1'b1;
    if (tx_en_prev && tx_en) long_en_err = 1'b1;
    tx_en_prev = tx_en;
    if (tx_en === 1'b1) begin
      if (log_n < 64) begin
        log_data[log_n] = tx_data;
        log_gid[log_n]  = grant_id;
      end
      log_n  = log_n + 1;
      tot_en = tot_en + 1;
    end
    if ($countones(req_ready) > 1) multi_err = 1'b1;
    if ((req_ready & ~(NR'(1) << grant_id)) != '0) stray_err = 1'b1;
    for (int r = 0; r < NR; r++) begin
      req_valid[r]         = (src_rd[r] != src_wr[r]);
      req_data[r*8 +: 8]   = src_mem[r][src_rd[r] % 16][7:0];
      req_last[r]          = src_mem[r][src_rd[r] % 16][8];
    end
    acc_pend = req_valid & req_ready & {NR{~rst}};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_wr[r] % 16] = {l, d};
    src_wr[r] = src_wr[r] + 1;
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_n < n && k < 400) begin
      tick();
      k++;
    end
    chk("wait_log", 32'(log_n >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (active !== 1'b0 && k < 400) begin
      tick();
      k++;
    end
    chk("idle_active", 32'(active), 32'd0);
    chk("idle_busy", 32'(tx_busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    int n;
    int k;
    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < 16; i++) src_mem[r][i] = 9'h000;
    end
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    rst       = 1'b1;
    repeat (2) tick();

    // Reset values
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_abort", 32'(lock_abort), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte from requester 0
    base = log_n;
    push(0, 8'hA5, 1'b1);
    wait_log(base + 1);
    chk("single_data", 32'(log_data[base]), 32'hA5);
    chk("single_gid", 32'(log_gid[base]), 32'd0);
    chk("single_active", 32'(active), 32'd1);
    wait_idle();
    // Pointer now at 1: requester 1 beats requester 0
    base = log_n;
    push(0, 8'h5A, 1'b1);
    push(1, 8'h11, 1'b1);
    wait_log(base + 2);
    chk("rrptr_first", 32'(log_data[base]), 32'h11);
    chk("rrptr_first_gid", 32'(log_gid[base]), 32'd1);
    chk("rrptr_second", 32'(log_data[base+1]), 32'h5A);
    wait_idle();

    // Contention: all four valid, two single-byte bursts each
    do_reset();
    base = log_n;
    for (int r = 0; r < NR; r++) begin
      push(r, 8'h10 + 8'(r), 1'b1);
      push(r, 8'h10 + 8'(r), 1'b1);
    end
    wait_log(base + 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("contend_data%0d", i), 32'(log_data[base+i]), 32'h10 + 32'(i % 4));
      chk($sformatf("contend_gid%0d", i), 32'(log_gid[base+i]), 32'(i % 4));
    end
    wait_idle();

    // Burst lock: requester 0 sends three bytes while requester 1 waits
    do_reset();
    base = log_n;
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    push(1, 8'hB1, 1'b1);
    wait_log(base + 4);
    chk("burst_b0", 32'(log_data[base]), 32'h01);
    chk("burst_b1", 32'(log_data[base+1]), 32'h02);
    chk("burst_b2", 32'(log_data[base+2]), 32'h03);
    chk("burst_b3", 32'(log_data[base+3]), 32'hB1);
    chk("burst_gid2", 32'(log_gid[base+2]), 32'd0);
    chk("burst_gid3", 32'(log_gid[base+3]), 32'd1);
    wait_idle();

    // Lock timeout: requester 0 sends a non-final byte then goes quiet
    do_reset();
    base = log_n;
    push(0, 8'h55, 1'b0);
    push(1, 8'h66, 1'b1);
    wait_log(base + 1);
    k = 0;
    while (req_ready[0] !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("lock_reissue", 32'(req_ready[0]), 32'd1);
    n = 0;
    while (lock_abort !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("abort_delay", 32'(n), 32'd16);
    chk("abort_active", 32'(active), 32'd0);
    tick();
    chk("abort_width", 32'(lock_abort), 32'd0);
    chk("abort_regrant", 32'(grant_id), 32'd1);
    wait_log(base + 2);
    chk("abort_next_data", 32'(log_data[base+1]), 32'h66);
    chk("abort_next_gid", 32'(log_gid[base+1]), 32'd1);
    wait_idle();

    // Reset while the UART is mid-byte
    do_reset();
    base = log_n;
    push(2, 8'h77, 1'b1);
    wait_log(base + 1);
    k = 0;
    while (tx_busy !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    tick();
    chk("mid_busy", 32'(tx_busy), 32'd1);
    chk("mid_gid", 32'(grant_id), 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_en", 32'(tx_en), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_abort", 32'(lock_abort), 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("mid_no_spurious", 32'(log_n), 32'(base + 1));
    push(3, 8'h99, 1'b1);
    push(0, 8'h88, 1'b1);
    wait_log(base + 3);
    chk("mid_next_data", 32'(log_data[base+1]), 32'h88);
    chk("mid_next_gid", 32'(log_gid[base+1]), 32'd0);
    chk("mid_then_data", 32'(log_data[base+2]), 32'h99);
    chk("mid_then_gid", 32'(log_gid[base+2]), 32'd3);
    wait_idle();

    // Run-wide protocol observations
    chk("latency_1cyc", 32'(lat_err), 32'd0);
    chk("tx_en_width", 32'(long_en_err), 32'd0);
    chk("ready_onehot", 32'(multi_err), 32'd0);
    chk("ready_granted_only", 32'(stray_err), 32'd0);
    chk("accept_vs_tx_en", 32'(tot_acc), 32'(tot_en));
    chk("tx_en_count", 32'(tot_en), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
